// File: rtl/tcore_param.sv
// Shared core types and helpers used by the fetch front end.
// Provides: inst_t (32-bit instruction word), fa_state_e (fetch-align state),
//           is_rvc() (compressed-instruction length test on opcode bits [1:0]).
package tcore_param;

  typedef logic [31:0] inst_t;

  // HALF: the holding register carries the halfword located at the fetch pc.
  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } fa_state_e;

  // A 16-bit instruction is any encoding whose two low bits are not 2'b11.
  function automatic logic is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction

endpackage

// File: rtl/t_fetch_align.sv
// Fetch aligner: turns a stream of word-aligned fetch words into aligned
// 16/32-bit instructions with their pc, pc+2 and pc+4.
// Ports: clk_i/rst_ni (async active-high reset); stall_i holds everything;
//   flush_i/flush_pc_i redirect from execute; spec_taken_i/spec_pc_i redirect
//   from the predictor on an accepted instruction; fetch_addr_o/fetch_valid_i/
//   fetch_word_i form the fetch interface; inst_o/is_comp_o/pc_o/pc2_o/pc4_o/
//   inst_valid_o present the instruction combinationally (zero latency).
// Build option: define FETCH_ALIGN_RVC_EN to accept compressed instructions;
//   without it every word is a 32-bit instruction and the pc stays word-aligned.
module t_fetch_align
  import tcore_param::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        spec_taken_i,
  input  logic [31:0] spec_pc_i,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_word_i,
  output inst_t       inst_o,
  output logic        is_comp_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc2_o,
  output logic [31:0] pc4_o,
  output logic        inst_valid_o
);

`ifdef FETCH_ALIGN_RVC_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

  logic [31:0] pc_q, pc_d;
  logic [15:0] half_q, half_d;
  fa_state_e   state_q, state_d;

  logic [31:0] fetch_base;
  inst_t       inst_raw;
  logic        comp_raw;
  logic        produce;    // an instruction can be presented this cycle
  logic        stash;      // odd-halfword start of a 32-bit instruction
  logic [31:0] adv;        // pc increment when the instruction is accepted
  logic [15:0] half_nxt;   // holding register value if this cycle advances
  fa_state_e   state_acc;  // state if this cycle advances

  always_comb begin
    fetch_base = {pc_q[31:2], 2'b00};
    // In HALF the halfword at pc is already held, so fetch the following word.
    fetch_addr_o = (state_q == HALF) ? fetch_base + 32'd4 : fetch_base;

    inst_raw  = '0;
    comp_raw  = 1'b0;
    produce   = 1'b0;
    stash     = 1'b0;
    adv       = 32'd4;
    half_nxt  = half_q;
    state_acc = EMPTY;

`ifdef FETCH_ALIGN_RVC_EN
    case (state_q)
      EMPTY: begin
        if (fetch_valid_i) begin
          if (!pc_q[1]) begin
            if (is_rvc(fetch_word_i[1:0])) begin
              inst_raw  = {16'h0000, fetch_word_i[15:0]};
              comp_raw  = 1'b1;
              produce   = 1'b1;
              adv       = 32'd2;
              half_nxt  = fetch_word_i[31:16];
              state_acc = HALF;
            end else begin
              inst_raw = fetch_word_i;
              produce  = 1'b1;
            end
          end else begin
            // Low halfword lies before pc and is ignored.
            if (is_rvc(fetch_word_i[17:16])) begin
              inst_raw = {16'h0000, fetch_word_i[31:16]};
              comp_raw = 1'b1;
              produce  = 1'b1;
              adv      = 32'd2;
            end else begin
              stash    = 1'b1;
              half_nxt = fetch_word_i[31:16];
            end
          end
        end
      end
      HALF: begin
        if (is_rvc(half_q[1:0])) begin
          inst_raw = {16'h0000, half_q};
          comp_raw = 1'b1;
          produce  = 1'b1;
          adv      = 32'd2;
        end else if (fetch_valid_i) begin
          // Straddling instruction: upper half of the new word stays held.
          inst_raw  = {fetch_word_i[15:0], half_q};
          produce   = 1'b1;
          half_nxt  = fetch_word_i[31:16];
          state_acc = HALF;
        end
      end
      default: ;
    endcase
`else
    if (fetch_valid_i) begin
      inst_raw = fetch_word_i;
      produce  = 1'b1;
    end
`endif

    inst_valid_o = produce && !flush_i && !rst_ni;
    inst_o       = inst_valid_o ? inst_raw : '0;
    is_comp_o    = inst_valid_o && comp_raw;
    pc_o         = pc_q;
    pc2_o        = pc_q + 32'd2;
    pc4_o        = pc_q + 32'd4;

    pc_d    = pc_q;
    half_d  = half_q;
    state_d = state_q;
    if (flush_i) begin
      pc_d    = flush_pc_i;
      state_d = EMPTY;
    end else if (!stall_i) begin
      if (inst_valid_o) begin
        if (spec_taken_i) begin
          pc_d    = spec_pc_i;
          state_d = EMPTY;
        end else begin
          pc_d    = pc_q + adv;
          half_d  = half_nxt;
          state_d = state_acc;
        end
      end else if (stash) begin
        // pc stays on the held halfword; only the fetch address moves on.
        half_d  = half_nxt;
        state_d = HALF;
      end
    end
    pc_d = pc_d & PC_MASK;
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      pc_q    <= RESET_PC & PC_MASK;
      half_q  <= '0;
      state_q <= EMPTY;
    end else begin
      pc_q    <= pc_d;
      half_q  <= half_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_t_fetch_align.sv
module tb_t_fetch_align;
  import tcore_param::*;

`ifdef FETCH_ALIGN_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  localparam bit N = 1'b0;
  localparam bit Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst, stall, flush, spec, fv;
  logic [31:0] fpc, spc, word;
  logic [31:0] fa, pc, pc2, pc4;
  inst_t       inst;
  logic        comp, valid;

  always #5 clk = ~clk;

  t_fetch_align #(.RESET_PC(32'h4000_0000)) dut (
    .clk_i(clk), .rst_ni(rst), .stall_i(stall), .flush_i(flush),
    .flush_pc_i(fpc), .spec_taken_i(spec), .spec_pc_i(spc),
    .fetch_addr_o(fa), .fetch_valid_i(fv), .fetch_word_i(word),
    .inst_o(inst), .is_comp_o(comp), .pc_o(pc), .pc2_o(pc2), .pc4_o(pc4),
    .inst_valid_o(valid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus with expectations for both build options.
  typedef struct {
    bit rst, stall, flush; logic [31:0] fpc; bit spec; logic [31:0] spc;
    bit fv; logic [31:0] word;
    bit von; logic [31:0] ion; bit con; logic [31:0] pon, aon;
    bit voff; logic [31:0] ioff, poff, aoff;
  } vec_t;

  vec_t vecs[29];

  logic [31:0] mem[256];

  function automatic logic [15:0] mhalf(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  initial begin
    bit          ev, ec;
    logic [31:0] ei, ep, ea, mpc, einst;
    logic [15:0] h0;
    int          len, idle;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; spec = 1'b0; fv = 1'b0;
    fpc = '0; spc = '0; word = '0;

    //           rst stl fl fpc            sp spc            fv word
    //           | RVC on: v inst comp pc aon              | RVC off: v inst pc aoff
    vecs[0]  = '{Y,N,N,32'h0,N,32'h0,Y,32'h0000_0013, N,32'h0,N,32'h4000_0000,32'h4000_0000, N,32'h0,32'h4000_0000,32'h4000_0000};
    vecs[1]  = '{N,N,N,32'h0,N,32'h0,Y,32'h0000_0013, Y,32'h13,N,32'h4000_0000,32'h4000_0000, Y,32'h13,32'h4000_0000,32'h4000_0000};
    vecs[2]  = '{N,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'h4000_0004,32'h4000_0004, N,32'h0,32'h4000_0004,32'h4000_0004};
    vecs[3]  = '{Y,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'h4000_0000,32'h4000_0000, N,32'h0,32'h4000_0000,32'h4000_0000};
    vecs[4]  = '{N,N,N,32'h0,N,32'h0,Y,32'h0013_4501, Y,32'h4501,Y,32'h4000_0000,32'h4000_0000, Y,32'h0013_4501,32'h4000_0000,32'h4000_0000};
    vecs[5]  = '{N,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'h4000_0002,32'h4000_0004, N,32'h0,32'h4000_0004,32'h4000_0004};
    vecs[6]  = '{N,N,N,32'h0,N,32'h0,Y,32'h0000_1234, Y,32'h1234_0013,N,32'h4000_0002,32'h4000_0004, Y,32'h0000_1234,32'h4000_0004,32'h4000_0004};
    vecs[7]  = '{N,N,Y,32'h4000_0102,N,32'h0,Y,32'h4501_0000, N,32'h0,N,32'h4000_0006,32'h4000_0008, N,32'h0,32'h4000_0008,32'h4000_0008};
    vecs[8]  = '{N,N,N,32'h0,N,32'h0,Y,32'h4501_0000, Y,32'h4501,Y,32'h4000_0102,32'h4000_0100, Y,32'h4501_0000,32'h4000_0100,32'h4000_0100};
    vecs[9]  = '{N,N,N,32'h0,N,32'h0,Y,32'h0013_4501, Y,32'h4501,Y,32'h4000_0104,32'h4000_0104, Y,32'h0013_4501,32'h4000_0104,32'h4000_0104};
    vecs[10] = '{N,N,N,32'h0,Y,32'h4000_0200,Y,32'h0000_1234, Y,32'h1234_0013,N,32'h4000_0106,32'h4000_0108, Y,32'h0000_1234,32'h4000_0108,32'h4000_0108};
    vecs[11] = '{N,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'h4000_0200,32'h4000_0200, N,32'h0,32'h4000_0200,32'h4000_0200};
    vecs[12] = '{N,N,N,32'h0,N,32'h0,Y,32'h0013_4501, Y,32'h4501,Y,32'h4000_0200,32'h4000_0200, Y,32'h0013_4501,32'h4000_0200,32'h4000_0200};
    vecs[13] = '{N,Y,N,32'h0,N,32'h0,Y,32'h0017_1234, Y,32'h1234_0013,N,32'h4000_0202,32'h4000_0204, Y,32'h0017_1234,32'h4000_0204,32'h4000_0204};
    vecs[14] = vecs[13];
    vecs[15] = vecs[13];
    vecs[16] = '{N,N,N,32'h0,N,32'h0,Y,32'h0017_1234, Y,32'h1234_0013,N,32'h4000_0202,32'h4000_0204, Y,32'h0017_1234,32'h4000_0204,32'h4000_0204};
    vecs[17] = '{N,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'h4000_0206,32'h4000_0208, N,32'h0,32'h4000_0208,32'h4000_0208};
    vecs[18] = '{Y,N,N,32'h0,N,32'h0,Y,32'h0000_0013, N,32'h0,N,32'h4000_0000,32'h4000_0000, N,32'h0,32'h4000_0000,32'h4000_0000};
    vecs[19] = '{N,N,N,32'h0,N,32'h0,Y,32'h0000_0013, Y,32'h13,N,32'h4000_0000,32'h4000_0000, Y,32'h13,32'h4000_0000,32'h4000_0000};
    vecs[20] = '{N,N,Y,32'h4000_0012,N,32'h0,Y,32'h0000_0013, N,32'h0,N,32'h4000_0004,32'h4000_0004, N,32'h0,32'h4000_0004,32'h4000_0004};
    vecs[21] = '{N,N,N,32'h0,N,32'h0,Y,32'h0003_ABCD, N,32'h0,N,32'h4000_0012,32'h4000_0010, Y,32'h0003_ABCD,32'h4000_0010,32'h4000_0010};
    vecs[22] = '{N,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'h4000_0012,32'h4000_0014, N,32'h0,32'h4000_0014,32'h4000_0014};
    vecs[23] = '{N,N,N,32'h0,N,32'h0,Y,32'h0001_5678, Y,32'h5678_0003,N,32'h4000_0012,32'h4000_0014, Y,32'h0001_5678,32'h4000_0014,32'h4000_0014};
    vecs[24] = '{N,N,N,32'h0,N,32'h0,N,32'h0, Y,32'h0000_0001,Y,32'h4000_0016,32'h4000_0018, N,32'h0,32'h4000_0018,32'h4000_0018};
    vecs[25] = '{N,Y,Y,32'hFFFF_FFFC,N,32'h0,N,32'h0, N,32'h0,N,32'h4000_0018,32'h4000_0018, N,32'h0,32'h4000_0018,32'h4000_0018};
    vecs[26] = '{N,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'hFFFF_FFFC,32'hFFFF_FFFC, N,32'h0,32'hFFFF_FFFC,32'hFFFF_FFFC};
    vecs[27] = '{N,N,N,32'h0,N,32'h0,Y,32'h0000_0013, Y,32'h13,N,32'hFFFF_FFFC,32'hFFFF_FFFC, Y,32'h13,32'hFFFF_FFFC,32'hFFFF_FFFC};
    vecs[28] = '{N,N,N,32'h0,N,32'h0,N,32'h0, N,32'h0,N,32'h0000_0000,32'h0000_0000, N,32'h0,32'h0000_0000,32'h0000_0000};

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; flush = vecs[i].flush;
      fpc = vecs[i].fpc; spec = vecs[i].spec; spc = vecs[i].spc;
      fv = vecs[i].fv; word = vecs[i].word;
      #2;
      ev = RVC ? vecs[i].von : vecs[i].voff;
      ei = RVC ? vecs[i].ion : vecs[i].ioff;
      ec = RVC ? vecs[i].con : 1'b0;
      ep = RVC ? vecs[i].pon : vecs[i].poff;
      ea = RVC ? vecs[i].aon : vecs[i].aoff;
      check($sformatf("row%0d valid", i), {31'b0, valid}, {31'b0, ev});
      check($sformatf("row%0d pc", i), pc, ep);
      check($sformatf("row%0d pc2", i), pc2, ep + 32'd2);
      check($sformatf("row%0d pc4", i), pc4, ep + 32'd4);
      check($sformatf("row%0d fetch_addr", i), fa, ea);
      if (ev || vecs[i].rst) begin
        check($sformatf("row%0d inst", i), inst, ei);
        check($sformatf("row%0d is_comp", i), {31'b0, comp}, {31'b0, ec});
      end
    end

    // Randomized run: memory-backed fetch, instruction stream decoded from memory.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; flush = 1'b0; spec = 1'b0; fv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mpc = 32'h4000_0000;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 29) == 0);
      spec  = ($urandom_range(0, 9) == 0);
      fv    = ($urandom_range(0, 9) < 6);
      fpc   = 32'h4000_0000 | ($urandom & 32'h0000_07FE);
      spc   = 32'h4000_0000 | ($urandom & 32'h0000_07FE);
      if (!RVC) begin
        fpc[1] = 1'b0;
        spc[1] = 1'b0;
      end
      word = fv ? mem[fa[9:2]] : $urandom;
      #2;
      check("rnd pc", pc, mpc);
      check("rnd pc2", pc2, mpc + 32'd2);
      check("rnd pc4", pc4, mpc + 32'd4);
      check("rnd fetch_addr align", {30'b0, fa[1:0]}, 32'h0);
      if (flush) begin
        check("rnd valid during flush", {31'b0, valid}, 32'h0);
        mpc  = fpc;
        idle = 0;
      end else if (valid) begin
        h0 = mhalf(mpc);
        if (RVC && h0[1:0] != 2'b11) begin
          einst = {16'h0000, h0};
          ec    = 1'b1;
          len   = 2;
        end else begin
          einst = {mhalf(mpc + 32'd2), h0};
          ec    = 1'b0;
          len   = 4;
        end
        check("rnd inst", inst, einst);
        check("rnd is_comp", {31'b0, comp}, {31'b0, ec});
        if (!stall) mpc = spec ? spc : mpc + len;
        idle = 0;
      end else begin
        idle++;
        if (idle > 50) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rnd progress: no instruction for %0d cycles at pc %h, expected one within 50", idle, mpc);
          break;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
